// File: rtl/tas_pkg.sv
// tas_pkg: shared UART receive state encoding and frame constants
package tas_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk_50 or negedge reset_n)
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receive front-end strobing data bits into a downstream shift register
module uart_rx_ctrl
  import tas_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic serial_in,
  output logic serial_data,
  output logic data_ena,
  output logic byte_valid,
  output logic framing_err,
  output logic busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_END = CW'(HALF_BIT - 1);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);
  rx_state_t state, state_n;
  logic [CW-1:0] clk_cnt, cnt_n;
  logic [2:0] bit_idx, idx_n;
  logic rx_s, sd_n, ena_n, bv_n, fe_n;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_50 (clk_50),
    .reset_n(reset_n),
    .d      (serial_in),
    .q      (rx_s)
  );
  always_comb begin
    state_n = state;
    cnt_n   = clk_cnt + CW'(1);
    idx_n   = bit_idx;
    sd_n    = serial_data;
    ena_n   = 1'b0;
    bv_n    = 1'b0;
    fe_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        state_n = rx_s ? IDLE : START;
      end
      START:
        if (clk_cnt == MID_END) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      DATA:
        if (clk_cnt == BIT_END) begin
          cnt_n   = '0;
          sd_n    = rx_s;
          ena_n   = 1'b1;
          idx_n   = bit_idx + 3'd1;
          state_n = (bit_idx == LAST_IDX) ? STOP : DATA;
        end
      STOP:
        if (clk_cnt == BIT_END) begin
          cnt_n   = '0;
          bv_n    = rx_s;
          fe_n    = !rx_s;
          state_n = rx_s ? IDLE : WAIT_IDLE;
        end
      WAIT_IDLE: begin
        // a line stuck low must return high before a new start bit is accepted
        cnt_n   = '0;
        state_n = rx_s ? IDLE : WAIT_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_50 or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      serial_data <= 1'b0;
      data_ena    <= 1'b0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= cnt_n;
      bit_idx     <= idx_n;
      serial_data <= sd_n;
      data_ena    <= ena_n;
      byte_valid  <= bv_n;
      framing_err <= fe_n;
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl with a downstream right-shift register
module tb_uart_rx_ctrl;
  localparam int CPB = 10;
  localparam int HALF = 5;
  localparam int BV_LAT = 1 + 2 + HALF + 9 * CPB;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_bv;
    logic       exp_fe;
  } vec_t;
  logic clk_50 = 1'b0;
  logic reset_n = 1'b0;
  logic serial_in = 1'b1;
  logic serial_data, data_ena, byte_valid, framing_err, busy;
  logic [7:0] sr;
  int checks = 0, failures = 0, cyc = 0;
  int ena_cnt = 0, bv_cnt = 0, fe_cnt = 0, bad_overlap = 0, busy_cycles = 0;
  int ena_times[$];
  logic bits[$];
  int bv_time = 0;
  logic [7:0] bv_sr = '0;
  vec_t vecs[6];
  uart_rx_ctrl #(.CLK_FREQ(50_000_000), .BAUD(5_000_000)) dut (
    .clk_50     (clk_50),
    .reset_n    (reset_n),
    .serial_in  (serial_in),
    .serial_data(serial_data),
    .data_ena   (data_ena),
    .byte_valid (byte_valid),
    .framing_err(framing_err),
    .busy       (busy)
  );
  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;
  always @(posedge clk_50 or negedge reset_n)
    if (!reset_n) sr <= '0;
    else if (data_ena) sr <= {serial_data, sr[7:1]};
  always @(negedge clk_50) begin
    if (data_ena) begin
      ena_cnt++;
      ena_times.push_back(cyc);
      bits.push_back(serial_data);
    end
    if (byte_valid) begin
      bv_cnt++;
      bv_time = cyc;
      bv_sr = sr;
    end
    if (framing_err) fe_cnt++;
    if ((byte_valid && framing_err) || ((byte_valid || framing_err) && data_ena)) bad_overlap++;
    if (busy) busy_cycles++;
  end
  task automatic check(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask
  task automatic send_frame(logic [7:0] b, logic stop);
    serial_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick(CPB);
    end
    serial_in = stop;
    tick(CPB);
  endtask
  task automatic verify(string nm, logic [7:0] b, logic exp_bv, logic exp_fe, int start, int e0, int b0, int f0);
    logic [7:0] got;
    int bad_gap;
    got = '0;
    bad_gap = 0;
    check({nm, " ena_count"}, ena_cnt - e0, 8);
    if (bits.size() >= e0 + 8) begin
      for (int i = 0; i < 8; i++) got[i] = bits[e0 + i];
      for (int i = 1; i < 8; i++) if (ena_times[e0 + i] - ena_times[e0 + i - 1] != CPB) bad_gap++;
    end
    check({nm, " bits"}, int'(got), int'(b));
    check({nm, " ena_spacing_errs"}, bad_gap, 0);
    check({nm, " byte_valid_count"}, bv_cnt - b0, int'(exp_bv));
    check({nm, " framing_err_count"}, fe_cnt - f0, int'(exp_fe));
    if (exp_bv) begin
      check({nm, " shift_reg"}, int'(bv_sr), int'(b));
      check({nm, " bv_latency"}, bv_time - start, BV_LAT);
    end
  endtask
  task automatic run_frame(string nm, logic [7:0] b, logic stop, logic exp_bv, logic exp_fe, int gap);
    int start, e0, b0, f0;
    start = cyc;
    e0 = ena_cnt;
    b0 = bv_cnt;
    f0 = fe_cnt;
    send_frame(b, stop);
    serial_in = 1'b1;
    if (gap > 0) tick(gap);
    verify(nm, b, exp_bv, exp_fe, start, e0, b0, f0);
  endtask
  initial begin
    int e0, b0, f0, bc0, t1;
    logic [7:0] rb;
    logic rstop;
    bit seen;
    vecs[0] = '{8'hA5, 1'b1, 2, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 5, 1'b1, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 10, 1'b0, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 3, 1'b1, 1'b0};
    vecs[5] = '{8'h7E, 1'b0, 8, 1'b0, 1'b1};
    tick(3);
    check("reset serial_data", serial_data, 0);
    check("reset data_ena", data_ena, 0);
    check("reset byte_valid", byte_valid, 0);
    check("reset framing_err", framing_err, 0);
    check("reset busy", busy, 0);
    reset_n = 1'b1;
    bc0 = busy_cycles;
    tick(1000);
    check("idle ena", ena_cnt, 0);
    check("idle byte_valid", bv_cnt, 0);
    check("idle framing_err", fe_cnt, 0);
    check("idle busy_cycles", busy_cycles - bc0, 0);
    for (int i = 0; i < 6; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop, vecs[i].exp_bv, vecs[i].exp_fe, vecs[i].gap);
    e0 = ena_cnt; b0 = bv_cnt; f0 = fe_cnt; bc0 = busy_cycles;
    serial_in = 1'b0;
    tick(3);
    serial_in = 1'b1;
    tick(8);
    check("glitch busy_after", busy, 0);
    tick(20);
    check("glitch busy_cycles", busy_cycles - bc0, HALF);
    check("glitch ena", ena_cnt - e0, 0);
    check("glitch byte_valid", bv_cnt - b0, 0);
    check("glitch framing_err", fe_cnt - f0, 0);
    e0 = ena_cnt; b0 = bv_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    tick(40);
    check("held_low busy", busy, 1);
    check("held_low framing_err", fe_cnt - f0, 1);
    check("held_low byte_valid", bv_cnt - b0, 0);
    check("held_low ena", ena_cnt - e0, 8);
    serial_in = 1'b1;
    tick(5);
    check("held_low busy_released", busy, 0);
    run_frame("after_fe_81", 8'h81, 1'b1, 1'b1, 1'b0, 4);
    run_frame("b2b_00", 8'h00, 1'b1, 1'b1, 1'b0, 0);
    t1 = bv_time;
    run_frame("b2b_FF", 8'hFF, 1'b1, 1'b1, 1'b0, 4);
    check("b2b bv_spacing", bv_time - t1, 10 * CPB);
    e0 = ena_cnt; b0 = bv_cnt; f0 = fe_cnt;
    rb = 8'h5A;
    serial_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      serial_in = rb[i];
      tick(CPB);
    end
    serial_in = rb[3];
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_50);
      seen = (ena_cnt - e0) >= 4;
    end
    check("reset_mid 4th_strobe_seen", int'(seen), 1);
    reset_n = 1'b0;
    #1;
    check("reset_mid serial_data", serial_data, 0);
    check("reset_mid data_ena", data_ena, 0);
    check("reset_mid byte_valid", byte_valid, 0);
    check("reset_mid framing_err", framing_err, 0);
    check("reset_mid busy", busy, 0);
    serial_in = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(120);
    check("reset_mid no_byte_valid", bv_cnt - b0, 0);
    check("reset_mid no_framing_err", fe_cnt - f0, 0);
    check("reset_mid ena_total", ena_cnt - e0, 4);
    run_frame("after_reset_C3", 8'hC3, 1'b1, 1'b1, 1'b0, 3);
    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom);
      rstop = $urandom_range(0, 3) != 0;
      run_frame($sformatf("rand%0d", i), rb, rstop, rstop, !rstop,
                rstop ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 12)));
    end
    check("pulse_overlap", bad_overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Serial receive front-end that sits directly upstream of the 8-bit serial-to-parallel shift register. It synchronises the asynchronous serial line and detects UART frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. For each data bit it drives serial_data together with a one-cycle data_ena strobe. After a valid stop bit it flags the byte as complete, so downstream logic can latch the shift register's parallel output.

Parameters:
CLK_FREQ, 50_000_000, clk_50 frequency in Hz
BAUD, 115_200, line bit rate in bit/s
CLKS_PER_BIT, CLK_FREQ/BAUD (434), clocks per bit, localparam, must be >= 4
HALF_BIT, CLKS_PER_BIT/2 (217), start-bit mid-sample offset, localparam

Ports:
clk_50  input  1  50 MHz system clock
reset_n  input  1  asynchronous reset, active-low
serial_in  input  1  asynchronous UART line, idle high
serial_data  output  1  sampled data bit; feeds shift register serial input
data_ena  output  1  one-cycle strobe; shift register captures serial_data
byte_valid  output  1  one-cycle pulse; all 8 bits shifted and stop bit good
framing_err  output  1  one-cycle pulse; stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: reset_n asynchronous, active-low; clock clk_50. All outputs reset to 0. Synchroniser flops reset to 1 (idle line). State IDLE; all counters 0.
- Synchroniser: 2-FF on serial_in, giving rx_s. All decisions use rx_s, so there is 2 cycles of input latency.
- Counters: bit-timer clk_cnt, width $clog2(CLKS_PER_BIT), counts up and is cleared on every state change. Bit counter bit_idx is 3 bits.
- States:
  - IDLE: rx_s==0 -> START, clk_cnt=0.
  - START: when clk_cnt==HALF_BIT-1, sample rx_s. If 0 -> DATA, clk_cnt=0, bit_idx=0. If 1 -> IDLE (glitch rejected, no outputs).
  - DATA: when clk_cnt==CLKS_PER_BIT-1, register serial_data<=rx_s and data_ena<=1 for exactly one cycle; clk_cnt=0. If bit_idx==7 -> STOP, else bit_idx++.
  - STOP: when clk_cnt==CLKS_PER_BIT-1, sample rx_s. If 1 -> byte_valid pulse, then IDLE. If 0 -> framing_err pulse, then WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then IDLE. This prevents a held-low line re-triggering as a start bit.
- Output timing:
  - serial_data and data_ena are registered and change in the same cycle.
  - serial_data holds its value between strobes.
  - Exactly 8 data_ena strobes per accepted frame, bit0 first, so the downstream right-shifting register holds the byte with bit0 at parallel_out[0].
  - byte_valid fires CLKS_PER_BIT cycles after the 8th data_ena; the shift register is already stable at that point.
- Boundary conditions:
  - Back-to-back frames: leaving STOP to IDLE with rx_s==0 on the next cycle starts a new frame immediately, with no dead cycles.
  - byte_valid and framing_err are mutually exclusive. Neither can coincide with data_ena.
  - Reset mid-frame aborts immediately. A partial frame yields no byte_valid. The downstream register's contents are not this block's concern.
  - A line held low indefinitely produces one framing_err per low period, then waits in WAIT_IDLE.

Decomposition:
- Package tas_pkg holds:
  - the state enum rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE} as logic [2:0]
  - the frame constant DATA_BITS=8
- Sub-module sync_2ff (parameterised reset value, default 1) is reusable for other async inputs.
- The FSM and counters stay inline.

Test Plan:
Use CLK_FREQ=50_000_000 and BAUD=5_000_000, giving CLKS_PER_BIT=10 and HALF_BIT=5. Instantiate with the shift register downstream.
1. Send frame 0xA5 with a good stop bit -> 8 data_ena pulses 10 clocks apart, with serial_data sequence 1,0,1,0,0,1,0,1. One byte_valid pulse. Shift register reads 0xA5 on byte_valid.
2. serial_in low for 3 clocks then high -> START returns to IDLE. No data_ena, byte_valid or framing_err. busy drops within 8 cycles.
3. Frame 0x3C with stop bit low, line held low 40 clocks, then high, then frame 0x81 -> one framing_err, no byte_valid. busy stays high until the line goes high. The next frame produces byte_valid and shift register value 0x81.
4. Frames 0x00 then 0xFF with zero idle between them -> two byte_valid pulses 100 clocks apart. Shift register reads 0x00 then 0xFF.
5. Assert reset_n low for 2 clocks after the 4th data_ena of 0x5A -> all outputs go 0 asynchronously and the state is IDLE. A following frame 0xC3 is received correctly.
6. Line held high for 1000 clocks after reset -> no pulses on any output; busy stays 0.
